echo_portal_mux: RTL and testbench
==================================

# echo_portal_mux

Parametrised N-channel indication concentrator for the echo portal stack. Accepts `heard` method calls from up to CHANNELS independent echo engines, buffers each in a per-channel FIFO, and serialises them round-robin onto a single 96-bit `pipe$enq` stream toward the indication output portal. It is the multi-channel successor to the single-engine Connect wiring. It adds buffering, fair arbitration, channel tagging and optional sequence numbering.

## Interface
Parameters:
- CHANNELS, 4: number of heard channels, 1..16.
- DEPTH, 4: per-channel FIFO entries; power of two, ≥2.

Ports. One clock; reset is synchronous and active-high.
- CLK  input  1  clock.
- RST  input  1  synchronous active-high reset.
- heard__ENA  input  CHANNELS  per-channel method enable. Channel c may assert bit c only while heard__RDY[c]=1.
- heard_meth  input  32*CHANNELS  method id; channel c in bits [32c+31:32c].
- heard_v  input  32*CHANNELS  payload; same packing as heard_meth.
- heard__RDY  output  CHANNELS  bit c = FIFO c not full.
- pipe$enq__ENA  output  1  message valid and transferred this cycle.
- pipe$enq_v  output  96  message.
- pipe$enq__RDY  input  1  downstream can accept.

## Operation
- ENA/RDY semantics: a transfer occurs in every cycle in which ENA=1. ENA is never asserted unless RDY=1. There is no separate valid/accept.
- Push: heard__ENA[c]=1 writes {meth, v} into FIFO c.
- Arbiter: maintains a last-grant pointer `last` (reset value CHANNELS-1).
  - The candidate is the first non-empty channel scanning last+1, last+2, … modulo CHANNELS.
  - pipe$enq__ENA = (any FIFO non-empty) & pipe$enq__RDY.
  - On transfer: pop the candidate FIFO and set last = candidate.
- Message format:
  - enq_v[95:88] = channel index, zero-extended.
  - enq_v[87:80] = 0.
  - enq_v[79:64] = seq field (see Configuration).
  - enq_v[63:32] = meth.
  - enq_v[31:0] = v.
- enq_v is driven from the candidate FIFO head whenever any FIFO is non-empty. It is all-zero otherwise.
- Full FIFO: heard__RDY[c]=0. A simultaneous pop on that channel does not raise RDY in the same cycle.
- Empty FIFO: no bypass. A pushed entry becomes visible to the arbiter in the following cycle.
- Push and pop on the same channel in the same cycle: both take effect and occupancy is unchanged.
- A heard__ENA[c] asserted while RDY[c]=0 is a protocol violation. It is ignored: no write and no state change.
- Reset mid-operation: all FIFOs empty, contents discarded, last=CHANNELS-1, sequence counters 0.

## Timing
- Reset values: heard__RDY = all ones, pipe$enq__ENA=0, pipe$enq_v=0.
- Latency: push at cycle t → earliest enq at cycle t+1.
- heard__RDY is a registered function of occupancy only. It has no combinational path from pipe$enq__RDY.
- pipe$enq__ENA has one combinational path, from pipe$enq__RDY. It has none from heard__ENA.
- Throughput: one message per cycle aggregate. With every channel continuously backlogged, each channel is served once every CHANNELS transfers.

## Configuration
- ECHO_PORTAL_MUX_SEQ_EN defined:
  - Each channel has a 16-bit message counter, reset to 0.
  - Its value is placed in enq_v[79:64] and incremented on each transfer from that channel.
  - The counter wraps from 16'hFFFF to 0.
- Undefined: enq_v[79:64]=0 and the counters are not instantiated.

## Structure
- Package echo_portal_pkg holds:
  - MSG_W=96, METH_W=32, V_W=32, CHAN_FIELD_W=8, SEQ_W=16.
  - A struct for the header fields.
  - A function that packs {chan, seq, meth, v} into 96 bits.
- Sub-module echo_portal_fifo:
  - 64-bit × DEPTH synchronous FIFO with synchronous active-high reset.
  - Ports: push, pop, full, empty, head.
  - Instantiated CHANNELS times by generate.
- Arbiter and message packing stay in the top module.

## Test plan
- Reset: hold RST 2 cycles → heard__RDY=4'b1111, pipe$enq__ENA=0, enq_v=0.
- Single message: push ch2 meth=1, v=32'h12345678 at t, pipe$enq__RDY=1 → at t+1, ENA=1 and enq_v=96'h02000000_00000001_12345678; in the next cycle ENA=0.
- Round-robin: preload ch0, ch1 and ch3 with 2 messages each, then hold RDY=1 → channel order is 0,1,3,0,1,3.
- Backpressure and full (DEPTH=4): hold RDY=0 and push ch1 five times → heard__RDY[1]=0 after 4 pushes and the 5th push is ignored. Release RDY → exactly 4 messages drain in order.
- Sequence numbers (SEQ_EN defined): 65537 messages on ch0 → last seq=0 after the wrap. A single ch1 message carries seq=0 (counters are independent).
- Reset mid-drain: assert RST with ch0 holding 3 entries → the next cycle shows all FIFOs empty and ENA=0. After re-fill, ch0 is served first.

Source files
------------

// File: rtl/echo_portal_pkg.sv
// echo_portal_pkg: shared widths, the 96-bit indication header layout and
// the helper that packs one outgoing pipe$enq message.
package echo_portal_pkg;

  localparam int MSG_W        = 96;
  localparam int METH_W       = 32;
  localparam int V_W          = 32;
  localparam int CHAN_FIELD_W = 8;
  localparam int SEQ_W        = 16;
  localparam int RSVD_W       = MSG_W - CHAN_FIELD_W - SEQ_W - METH_W - V_W;
  localparam int ENTRY_W      = METH_W + V_W;

  // Upper 32 bits of a message: channel tag, reserved byte, sequence number.
  typedef struct packed {
    logic [CHAN_FIELD_W-1:0] chan;
    logic [RSVD_W-1:0]       rsvd;
    logic [SEQ_W-1:0]        seq;
  } msg_hdr_t;

  // Build {chan, 8'h00, seq, meth, v}; the reserved byte is always zero.
  function automatic logic [MSG_W-1:0] pack_msg(
    input logic [CHAN_FIELD_W-1:0] chan,
    input logic [SEQ_W-1:0]        seq,
    input logic [METH_W-1:0]       meth,
    input logic [V_W-1:0]          v
  );
    msg_hdr_t hdr;
    hdr.chan = chan;
    hdr.rsvd = '0;
    hdr.seq  = seq;
    return {hdr, meth, v};
  endfunction

endpackage

// File: rtl/echo_portal_fifo.sv
// echo_portal_fifo: DEPTH x 64-bit synchronous FIFO holding {meth, v}.
// full_o/empty_o are registered from the next occupancy, so they never
// depend combinationally on push_i/pop_i. A push while full is dropped;
// a pop while empty is ignored. Storage is not cleared by reset, only the
// pointers and occupancy, which is enough to discard the contents.
module echo_portal_fifo
  import echo_portal_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] data_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [ENTRY_W-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q, count_d;
  logic               full_q, empty_q;
  logic               push_ok, pop_ok;

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  // Next occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers, occupancy and the registered full/empty flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/echo_portal_mux.sv
// echo_portal_mux: CHANNELS-way heard-indication concentrator. Each channel
// is buffered in its own echo_portal_fifo and a round-robin arbiter
// serialises the heads onto the single 96-bit pipe_enq stream.
//
// Handshake: every port pair uses ENA/RDY. A transfer happens in each cycle
// where ENA=1, and ENA is only raised while RDY=1. heard__RDY[c] comes
// straight from FIFO c's registered full flag; pipe_enq__ENA is
// (any FIFO non-empty) & pipe_enq__RDY, its only combinational input.
//
// Optional feature macro: ECHO_PORTAL_MUX_SEQ_EN adds a 16-bit wrapping
// per-channel message counter placed in enq_v[79:64]; without it that
// field is zero.
module echo_portal_mux
  import echo_portal_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [CHANNELS-1:0]        heard__ENA,
  input  logic [METH_W*CHANNELS-1:0] heard_meth,
  input  logic [V_W*CHANNELS-1:0]    heard_v,
  output logic [CHANNELS-1:0]        heard__RDY,
  output logic                       pipe_enq__ENA,
  output logic [MSG_W-1:0]           pipe_enq_v,
  input  logic                       pipe_enq__RDY
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] fifo_full;
  logic [CHANNELS-1:0] fifo_empty;
  logic [CHANNELS-1:0] fifo_pop;
  logic [ENTRY_W-1:0]  fifo_head [CHANNELS];

  logic [CW-1:0]       last_q;
  logic [CW-1:0]       cand;
  logic                any_ne;
  int                  idx;
  logic [ENTRY_W-1:0]  cand_head;
  logic [SEQ_W-1:0]    cand_seq;
  logic                enq_ena;

  // One FIFO per heard channel.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    echo_portal_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (heard__ENA[c]),
      .data_i  ({heard_meth[METH_W*c +: METH_W], heard_v[V_W*c +: V_W]}),
      .pop_i   (fifo_pop[c]),
      .full_o  (fifo_full[c]),
      .empty_o (fifo_empty[c]),
      .head_o  (fifo_head[c])
    );
    assign fifo_pop[c] = enq_ena & (cand == CW'(c));
  end

  assign heard__RDY = ~fifo_full;

  // Candidate: first non-empty channel scanning last+1, last+2, ... mod CHANNELS.
  always_comb begin
    cand   = last_q;
    any_ne = 1'b0;
    idx    = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(last_q) + i) % CHANNELS;
      if (!any_ne && !fifo_empty[idx]) begin
        any_ne = 1'b1;
        cand   = CW'(idx);
      end
    end
  end

  assign enq_ena = any_ne & pipe_enq__RDY;

  // Last-grant pointer moves to the channel just served.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q <= CW'(CHANNELS - 1);
    end else if (enq_ena) begin
      last_q <= cand;
    end
  end

`ifdef ECHO_PORTAL_MUX_SEQ_EN
  logic [SEQ_W-1:0] seq_q [CHANNELS];

  // Per-channel message counters, bumped on each transfer from that channel.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < CHANNELS; c++) seq_q[c] <= '0;
    end else if (enq_ena) begin
      seq_q[cand] <= seq_q[cand] + 1'b1;
    end
  end

  assign cand_seq = seq_q[cand];
`else
  assign cand_seq = '0;
`endif

  assign cand_head     = fifo_head[cand];
  assign pipe_enq__ENA = enq_ena;
  assign pipe_enq_v    = any_ne ? pack_msg(CHAN_FIELD_W'(cand), cand_seq,
                                           cand_head[ENTRY_W-1 -: METH_W],
                                           cand_head[V_W-1:0])
                                : '0;

endmodule

// File: tb/tb_echo_portal_mux.sv
// tb_echo_portal_mux: directed scenarios for echo_portal_mux (CHANNELS=4,
// DEPTH=4). Expected messages are queued in output order as stimulus is
// driven and compared whenever the DUT transfers on pipe_enq.
module tb_echo_portal_mux;

  localparam int CH = 4;
  localparam int DP = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [CH-1:0]    heard_ena;
  logic [32*CH-1:0] heard_meth;
  logic [32*CH-1:0] heard_v;
  logic [CH-1:0]    heard_rdy;
  logic             enq_ena;
  logic [95:0]      enq_v;
  logic             enq_rdy;

  logic [95:0]      exp_q[$];
  int               n_checks = 0;
  int               n_errors = 0;
  logic [15:0]      tb_seq [CH];

  echo_portal_mux #(
    .CHANNELS (CH),
    .DEPTH    (DP)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .heard__ENA    (heard_ena),
    .heard_meth    (heard_meth),
    .heard_v       (heard_v),
    .heard__RDY    (heard_rdy),
    .pipe_enq__ENA (enq_ena),
    .pipe_enq_v    (enq_v),
    .pipe_enq__RDY (enq_rdy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1);
  end

  // Checker
  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard push: build the message independently from the field layout.
  task automatic expect_msg(input int c, input logic [31:0] m, input logic [31:0] v);
    logic [15:0] s;
    s = 16'h0;
`ifdef ECHO_PORTAL_MUX_SEQ_EN
    s = tb_seq[c];
    tb_seq[c] = tb_seq[c] + 16'h1;
`endif
    exp_q.push_back({8'(c), 8'h00, s, m, v});
  endtask

  // Scoreboard compare on every transfer
  always @(negedge clk) begin
    if (!rst && enq_ena) begin
      if (exp_q.size() == 0) check_eq("unexpected_enq", {95'd0, enq_ena}, 96'd0);
      else                   check_eq("enq_v", enq_v, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int c = 0; c < CH; c++) tb_seq[c] = 16'h0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    heard_ena = '0;
    clear_model();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_chan(input int c, input logic [31:0] m, input logic [31:0] v);
    heard_meth[32*c +: 32] = m;
    heard_v[32*c +: 32]    = v;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("drain_empty", 96'(exp_q.size()), 96'd0);
  endtask

  initial begin
    logic [31:0] rm [2][CH];
    logic [31:0] rv [2][CH];
    logic [31:0] dv;
    logic [95:0] want;

    rst        = 1'b1;
    heard_ena  = '0;
    heard_meth = '0;
    heard_v    = '0;
    enq_rdy    = 1'b1;

    // Reset state
    do_reset();
    #3;
    check_eq("rst_rdy", 96'(heard_rdy), 96'hF);
    check_eq("rst_ena", 96'(enq_ena), 96'd0);
    check_eq("rst_enq_v", enq_v, 96'd0);

    // Single message: ch2, meth=1, v=0x12345678
    do_reset();
    enq_rdy   = 1'b1;
    heard_ena = 4'b0100;
    set_chan(2, 32'h1, 32'h12345678);
    expect_msg(2, 32'h1, 32'h12345678);
`ifndef ECHO_PORTAL_MUX_SEQ_EN
    check_eq("single_fmt", exp_q[0], 96'h02000000_00000001_12345678);
`endif
    #3;
    check_eq("no_bypass_ena", 96'(enq_ena), 96'd0);
    tick();
    heard_ena = '0;
    #3;
    check_eq("single_ena_t1", 96'(enq_ena), 96'd1);
    tick();
    #3;
    check_eq("single_ena_t2", 96'(enq_ena), 96'd0);
    check_eq("single_idle_v", enq_v, 96'd0);
    wait_drain(5);

    // Backpressure and full on ch1
    do_reset();
    enq_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dv = $urandom();
      heard_ena = 4'b0010;
      set_chan(1, 32'(k + 16'hA0), dv);
      if (k < 4) expect_msg(1, 32'(k + 16'hA0), dv);
      tick();
      #3;
      want = (k < 3) ? 96'd1 : 96'd0;
      check_eq("bp_rdy1", 96'(heard_rdy[1]), want);
      check_eq("bp_ena", 96'(enq_ena), 96'd0);
    end
    heard_ena = '0;
    tick();
    check_eq("bp_queued", 96'(exp_q.size()), 96'd4);
    enq_rdy = 1'b1;
    wait_drain(20);
    tick();
    tick();
    #3;
    check_eq("bp_rdy_after", 96'(heard_rdy), 96'hF);
    check_eq("bp_idle_ena", 96'(enq_ena), 96'd0);

    // Round-robin over ch0, ch1, ch3 with two messages each
    do_reset();
    enq_rdy = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < CH; c++) begin
        rm[r][c] = $urandom_range(0, 255);
        rv[r][c] = $urandom();
        set_chan(c, rm[r][c], rv[r][c]);
      end
      heard_ena = 4'b1011;
      tick();
    end
    heard_ena = '0;
    for (int r = 0; r < 2; r++) begin
      expect_msg(0, rm[r][0], rv[r][0]);
      expect_msg(1, rm[r][1], rv[r][1]);
      expect_msg(3, rm[r][3], rv[r][3]);
    end
    enq_rdy = 1'b1;
    wait_drain(20);

    // Reset mid-drain with ch0 holding 3 entries
    do_reset();
    enq_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dv = $urandom();
      heard_ena = 4'b0001;
      set_chan(0, 32'(k + 16'hC0), dv);
      if (k == 0) expect_msg(0, 32'(k + 16'hC0), dv);
      tick();
    end
    heard_ena = '0;
    enq_rdy   = 1'b1;
    tick();
    rst = 1'b1;
    clear_model();
    tick();
    rst = 1'b0;
    #3;
    check_eq("mid_rst_ena", 96'(enq_ena), 96'd0);
    check_eq("mid_rst_v", enq_v, 96'd0);
    check_eq("mid_rst_rdy", 96'(heard_rdy), 96'hF);
    tick();
    #3;
    check_eq("mid_rst_ena2", 96'(enq_ena), 96'd0);
    enq_rdy = 1'b0;
    set_chan(0, 32'h55, 32'hDEAD0000);
    set_chan(2, 32'h77, 32'hBEEF0002);
    heard_ena = 4'b0101;
    tick();
    heard_ena = '0;
    expect_msg(0, 32'h55, 32'hDEAD0000);
    expect_msg(2, 32'h77, 32'hBEEF0002);
    enq_rdy = 1'b1;
    wait_drain(10);

`ifdef ECHO_PORTAL_MUX_SEQ_EN
    // Sequence wrap on ch0, then an independent ch1 counter
    do_reset();
    enq_rdy = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      dv = $urandom();
      heard_ena = 4'b0001;
      set_chan(0, 32'h5E, dv);
      expect_msg(0, 32'h5E, dv);
      tick();
    end
    heard_ena = '0;
    wait_drain(10);
    heard_ena = 4'b0010;
    set_chan(1, 32'h1, 32'h11);
    expect_msg(1, 32'h1, 32'h11);
    tick();
    heard_ena = '0;
    wait_drain(10);
`endif

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
